// File: rtl/bus_read_arbiter.sv
// Arbitrates NREQ tri-state bus drivers and captures one word per grant.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin order; default is fixed priority.
module bus_read_arbiter #(
   parameter int WIDTH  = 16,
   parameter int NREQ   = 4,
   parameter int SETTLE = 1,
   localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  grant_en,
   input  logic [WIDTH-1:0] bus_in,
   output logic [WIDTH-1:0] rd_data,
   output logic [IW-1:0]    rd_src,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      HOLD
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q;
   logic [IW-1:0]   win_q;
   logic [IW-1:0]   pick;
   logic [IW-1:0]   ptr;
   logic            found;
   logic [NREQ-1:0] onehot;

   // Search starts at ptr and wraps; ptr is 0 under fixed priority.
   always_comb begin
      int t;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         t = int'(ptr) + k;
         if (t >= NREQ) t = t - NREQ;
         if (!found && req[t]) begin
            pick  = IW'(t);
            found = 1'b1;
         end
      end
      onehot       = '0;
      onehot[pick] = found;
   end

`ifdef BUS_ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (state_q == IDLE && found) begin
         ptr <= (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
      end
   end
`else
   assign ptr = '0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (found) state_d = DRIVE;
         DRIVE:   if (cnt_q == 4'd0) state_d = HOLD;
         HOLD:    if (rd_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant_en <= '0;
         cnt_q    <= '0;
         win_q    <= '0;
         rd_data  <= '0;
         rd_src   <= '0;
         rd_valid <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (found) begin
                  grant_en <= onehot;
                  win_q    <= pick;
                  cnt_q    <= 4'(SETTLE);
               end
            end
            DRIVE: begin
               if (cnt_q == 4'd0) begin
                  grant_en <= '0;
                  rd_data  <= bus_in;
                  rd_src   <= win_q;
                  rd_valid <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            HOLD: begin
               if (rd_ready) rd_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_q != IDLE);

endmodule
